seq_pattern_checker: RTL and testbench

//  Receive-side companion to the serial sequence generator (behavioral_model): samples its 1-bit output y,

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_pattern_checker_if.sv | 25 ++
 rtl/seq_shift_hist.sv | 33 +++
 rtl/seq_pattern_checker.sv | 152 +++++++++++++++
 tb/tb_seq_pattern_checker.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types for the serial pattern checker and the generator bench.
package seq_pkg;

    // Checker lock state; the generator bench decodes the same encoding.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int DEF_PATTERN_W = 4;
    localparam int DEF_LOCK_N    = 3;
    localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/seq_pattern_checker_if.sv
// Serial sample input plus status/counter outputs of the pattern checker.
interface seq_pattern_checker_if #(
    parameter int CNT_W = 8
);
    logic             y_in;
    logic             valid_in;
    logic             clear;
    logic             match;
    logic             locked;
    logic             slip;
    logic [CNT_W-1:0] match_count;
    logic [CNT_W-1:0] err_count;

    // Stimulus side: drives the serial stream, observes status.
    modport master (
        output y_in, valid_in, clear,
        input  match, locked, slip, match_count, err_count
    );

    // Checker side.
    modport slave (
        input  y_in, valid_in, clear,
        output match, locked, slip, match_count, err_count
    );
endinterface

// File: rtl/seq_shift_hist.sv
// History shift register and fill counter for the serial pattern checker.
// Only the PATTERN_W-1 most recent bits are stored; the window output
// appends the bit currently on the input so a match can be decided in
// the same cycle the completing bit arrives.
module seq_shift_hist #(
    parameter  int PATTERN_W = 4,
    localparam int FILL_W    = $clog2(PATTERN_W + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [PATTERN_W-1:0] window,
    output logic [FILL_W-1:0]    fill
);

    logic [PATTERN_W-2:0] hist_q;

    assign window = {hist_q, bit_in};

    // Shift in each valid sample; fill counts samples up to one full pattern.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            fill   <= '0;
        end else if (shift_en) begin
            hist_q <= window[PATTERN_W-2:0];
            if (fill != FILL_W'(PATTERN_W))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/seq_pattern_checker.sv
// Receive-side checker for the serial sequence generator: detects PATTERN
// in the sampled stream, locks after LOCK_N back-to-back periods, and
// flags a slip whenever an established lock is lost.
module seq_pattern_checker
    import seq_pkg::*;
#(
    parameter int                   PATTERN_W = DEF_PATTERN_W,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter int                   LOCK_N    = DEF_LOCK_N,
    parameter int                   CNT_W     = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_pattern_checker_if.slave  bus
);

    localparam int FILL_W = $clog2(PATTERN_W + 1);
    localparam int PH_W   = $clog2(PATTERN_W);
    localparam int GOOD_W = $clog2(LOCK_N + 1);

    localparam logic [PH_W-1:0]   PH_MAX    = PH_W'(PATTERN_W - 1);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(PATTERN_W - 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_N);

    // clear behaves exactly like reset and also discards a same-cycle sample.
    logic rst_all;
    assign rst_all = reset | bus.clear;

    logic                 vld;
    logic [PATTERN_W-1:0] window;
    logic [FILL_W-1:0]    fill;

    assign vld = bus.valid_in;

    seq_shift_hist #(
        .PATTERN_W (PATTERN_W)
    ) u_hist (
        .clk      (clk),
        .rst      (rst_all),
        .shift_en (vld),
        .bit_in   (bus.y_in),
        .window   (window),
        .fill     (fill)
    );

    // A hit needs PATTERN_W real samples including the current one.
    logic hit;
    logic due;
    logic [PH_W-1:0] ph_q;

    assign hit = vld && (fill >= FILL_NEED) && (window == PATTERN);
    assign due = vld && (ph_q == PH_MAX);

    // Phase: valid samples since the last hit, saturating at one period.
    always_ff @(posedge clk) begin
        if (rst_all)
            ph_q <= '0;
        else if (hit)
            ph_q <= '0;
        else if (vld && ph_q != PH_MAX)
            ph_q <= ph_q + 1'b1;
    end

    chk_state_t        state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;
    logic              slip_d;

    // Lock FSM state and good-period counter.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // Next-state: hits landing exactly one period apart build toward lock;
    // an off-period hit restarts verification, a missing hit drops back.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        slip_d  = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (hit) begin
                    state_d = VERIFY;
                    good_d  = GOOD_W'(1);
                end
            end
            VERIFY: begin
                if (hit && due) begin
                    good_d = good_q + 1'b1;
                    if (good_q + 1'b1 == GOOD_LOCK)
                        state_d = LOCKED;
                end else if (hit) begin
                    good_d = GOOD_W'(1);
                end else if (due) begin
                    state_d = SEARCH;
                    good_d  = '0;
                end
            end
            LOCKED: begin
                if (hit && due) begin
                    state_d = LOCKED;
                end else if (due) begin
                    state_d = SEARCH;
                    good_d  = '0;
                    slip_d  = 1'b1;
                end else if (hit) begin
                    state_d = VERIFY;
                    good_d  = GOOD_W'(1);
                    slip_d  = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                good_d  = '0;
            end
        endcase
    end

    logic             match_q;
    logic             slip_q;
    logic [CNT_W-1:0] match_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    // Registered pulses and saturating event counters.
    always_ff @(posedge clk) begin
        if (rst_all) begin
            match_q     <= 1'b0;
            slip_q      <= 1'b0;
            match_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            match_q <= hit;
            slip_q  <= slip_d;
            if (hit && match_cnt_q != '1)
                match_cnt_q <= match_cnt_q + 1'b1;
            if (slip_d && err_cnt_q != '1)
                err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign bus.match       = match_q;
    assign bus.slip        = slip_q;
    assign bus.locked      = (state_q == LOCKED);
    assign bus.match_count = match_cnt_q;
    assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_seq_pattern_checker.sv
// Directed bench for seq_pattern_checker: default instance plus a CNT_W=2
// instance fed the same stream for the saturation case.
module tb_seq_pattern_checker;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_pattern_checker_if #(.CNT_W(8)) if1 ();
    seq_pattern_checker_if #(.CNT_W(2)) if2 ();

    assign if2.y_in     = if1.y_in;
    assign if2.valid_in = if1.valid_in;
    assign if2.clear    = if1.clear;

    seq_pattern_checker #(.CNT_W(8)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    seq_pattern_checker #(.CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: inputs set on the falling edge, outputs visible #1 after rise.
    task automatic step(input logic r, input logic c, input logic v, input logic y);
        @(negedge clk);
        reset       = r;
        if1.clear    = c;
        if1.valid_in = v;
        if1.y_in     = y;
        @(posedge clk);
        #1;
    endtask

    task automatic bitv(input logic y);
        step(1'b0, 1'b0, 1'b1, y);
    endtask

    // One 4-bit period MSB first; no pattern completes mid-period in these streams.
    task automatic send4(input logic [3:0] p);
        for (int i = 3; i >= 0; i--) begin
            bitv(p[i]);
            if (i != 0) chk("mid_nomatch", 32'(if1.match), 32'd0);
        end
    endtask

    initial begin
        if1.clear    = 1'b0;
        if1.valid_in = 1'b0;
        if1.y_in     = 1'b0;

        // reset held with live data
        step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_match",  32'(if1.match),       32'd0);
        chk("rst_locked", 32'(if1.locked),      32'd0);
        chk("rst_slip",   32'(if1.slip),        32'd0);
        chk("rst_mcnt",   32'(if1.match_count), 32'd0);
        chk("rst_ecnt",   32'(if1.err_count),   32'd0);

        // single pattern then zeros
        bitv(1'b1); bitv(1'b0); bitv(1'b1);
        chk("t2_early", 32'(if1.match), 32'd0);
        bitv(1'b1);
        chk("t2_match",  32'(if1.match),       32'd1);
        chk("t2_mcnt",   32'(if1.match_count), 32'd1);
        chk("t2_locked", 32'(if1.locked),      32'd0);
        bitv(1'b0);
        chk("t2_pulse", 32'(if1.match), 32'd0);
        bitv(1'b0); bitv(1'b0); bitv(1'b0);
        chk("t2_noslip", 32'(if1.slip),        32'd0);
        chk("t2_mcnt2",  32'(if1.match_count), 32'd1);

        // clear with a valid sample: that sample must not enter the history
        step(1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_mcnt", 32'(if1.match_count), 32'd0);
        bitv(1'b0); bitv(1'b1); bitv(1'b1);
        chk("clr_discard", 32'(if1.match), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);

        // three back-to-back periods -> lock
        send4(4'b1011);
        chk("t3_m1",  32'(if1.match),       32'd1);
        chk("t3_lk1", 32'(if1.locked),      32'd0);
        send4(4'b1011);
        chk("t3_m2",  32'(if1.match),       32'd1);
        chk("t3_lk2", 32'(if1.locked),      32'd0);
        send4(4'b1011);
        chk("t3_m3",   32'(if1.match),       32'd1);
        chk("t3_lk3",  32'(if1.locked),      32'd1);
        chk("t3_mcnt", 32'(if1.match_count), 32'd3);

        // corrupted period -> slip
        send4(4'b1001);
        chk("t4_match",  32'(if1.match),     32'd0);
        chk("t4_slip",   32'(if1.slip),      32'd1);
        chk("t4_ecnt",   32'(if1.err_count), 32'd1);
        chk("t4_locked", 32'(if1.locked),    32'd0);
        bitv(1'b0);
        chk("t4_pulse", 32'(if1.slip),      32'd0);
        chk("t4_ecnt2", 32'(if1.err_count), 32'd1);

        // gaps with toggling data are invisible
        step(1'b0, 1'b1, 1'b0, 1'b0);
        bitv(1'b1); bitv(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_gap1", 32'(if1.match), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_gap3", 32'(if1.match), 32'd0);
        bitv(1'b1);
        chk("t5_early", 32'(if1.match), 32'd0);
        bitv(1'b1);
        chk("t5_match", 32'(if1.match),       32'd1);
        chk("t5_mcnt",  32'(if1.match_count), 32'd1);

        // five matches: narrow counter saturates
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            send4(4'b1011);
            chk("t6_mcnt8", 32'(if1.match_count), 32'(k));
        end
        chk("t6_mcnt2_sat", 32'(if2.match_count), 32'd3);
        chk("t6_lk2",       32'(if2.locked),      32'd1);
        chk("t6_lk1",       32'(if1.locked),      32'd1);

        // reset on the cycle that would complete a locked period
        bitv(1'b1); bitv(1'b0); bitv(1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        chk("t6_rst_match",  32'(if2.match),       32'd0);
        chk("t6_rst_locked", 32'(if2.locked),      32'd0);
        chk("t6_rst_slip",   32'(if2.slip),        32'd0);
        chk("t6_rst_mcnt2",  32'(if2.match_count), 32'd0);
        chk("t6_rst_mcnt8",  32'(if1.match_count), 32'd0);
        chk("t6_rst_lk1",    32'(if1.locked),      32'd0);
        chk("t6_rst_ecnt",   32'(if1.err_count),   32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end

endmodule
